// File: rtl/output_readback_pkg.sv
// Shared types and constants for the output-memory readback DMA.
package output_readback_pkg;

    localparam int OUT_MEM_DEPTH = 301056;
    localparam int OUT_MEM_AW    = 19;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} rdbk_state_t;

endpackage

// File: rtl/rdbk_fifo.sv
// First-word fall-through return-data FIFO; head_data is valid whenever empty is low.
module rdbk_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign do_pop    = pop && (count_q != '0);
    assign do_push   = push && ((count_q < (PW+1)'(DEPTH)) || do_pop);
    assign head_data = storage[rd_ptr];
    assign count     = count_q;
    assign empty     = (count_q == '0);

    // Storage is reset too so the stream data bus reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                storage[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                storage[wr_ptr] <= push_data;
                wr_ptr          <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/output_readback_dma.sv
// Streams a (base, len) window of output_memory onto a valid/ready stream.
// Optional feature macro: RDBK_CHECKSUM_EN (running sum of accepted beats on checksum).
module output_readback_dma
    import output_readback_pkg::*;
#(
    parameter int AW         = OUT_MEM_AW,
    parameter int DEPTH      = OUT_MEM_DEPTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_start,
    input  logic [AW-1:0] cmd_base,
    input  logic [AW:0]   cmd_len,
    input  logic          cmd_abort,
    output logic [AW-1:0] mem_rd_addr,
    output logic          mem_rd_en,
    input  logic [31:0]   mem_rd_data,
    output logic          m_valid,
    output logic [31:0]   m_data,
    output logic          m_last,
    input  logic          m_ready,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [31:0]   checksum
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    rdbk_state_t   state;
    rdbk_state_t   state_next;
    logic [AW-1:0] base_q;
    logic [AW:0]   len_q;
    logic [AW:0]   issued;
    logic [AW:0]   popped;
    logic          inflight;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] occupancy;
    logic          fifo_empty;
    logic [AW+1:0] cmd_end;
    logic          start_seen;
    logic          bounds_bad;
    logic          start_ok;
    logic          abort_act;
    logic          beat;
    logic          last_beat;
    logic          last_issue;

    assign start_seen = (state == IDLE) && cmd_start;
    assign cmd_end    = {2'b00, cmd_base} + {1'b0, cmd_len};
    assign bounds_bad = cmd_end > (AW+2)'(DEPTH);
    assign start_ok   = start_seen && !bounds_bad && (cmd_len != '0);
    assign abort_act  = cmd_abort && (state != IDLE);

    // Credits: words already in the FIFO plus the one read still in flight.
    assign occupancy  = fifo_count + CW'(inflight);
    assign m_valid    = !fifo_empty;
    assign m_last     = m_valid && (popped == len_q - (AW+1)'(1));
    assign beat       = m_valid && m_ready;
    assign last_beat  = beat && m_last;
    assign last_issue = mem_rd_en && (issued == len_q - (AW+1)'(1));
    assign mem_rd_addr = base_q + issued[AW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_ok) state_next = RUN;
            RUN:     if (abort_act) state_next = IDLE;
                     else if (last_issue) state_next = DRAIN;
            DRAIN:   if (abort_act || last_beat) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        mem_rd_en = (state == RUN) && (issued < len_q) && (occupancy < CW'(FIFO_DEPTH));
    end

    // Abort discards the read in flight by never letting it become a push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q   <= '0;
            len_q    <= '0;
            issued   <= '0;
            popped   <= '0;
            inflight <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done     <= 1'b0;
            err      <= 1'b0;
            inflight <= mem_rd_en && !abort_act;
            if (start_seen) begin
                if (bounds_bad) begin
                    err <= 1'b1;
                end else if (cmd_len == '0) begin
                    done <= 1'b1;
                end else begin
                    base_q <= cmd_base;
                    len_q  <= cmd_len;
                    issued <= '0;
                    popped <= '0;
                end
            end else if (!abort_act) begin
                if (mem_rd_en) issued <= issued + (AW+1)'(1);
                if (beat)      popped <= popped + (AW+1)'(1);
                if (last_beat) done   <= 1'b1;
            end
        end
    end

    rdbk_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight),
        .push_data (mem_rd_data),
        .pop       (beat),
        .flush     (abort_act),
        .head_data (m_data),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

`ifdef RDBK_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum <= '0;
        end else if (start_ok) begin
            checksum <= '0;
        end else if (beat) begin
            checksum <= checksum + m_data;
        end
    end
`else
    assign checksum = 32'h0;
`endif

endmodule

// File: tb/tb_output_readback_dma.sv
// Self-checking bench for output_readback_dma: memory model, transaction-level reference and directed/random commands.
module tb_output_readback_dma;

    localparam int DEPTH      = 301056;
    localparam int FIFO_DEPTH = 4;
`ifdef RDBK_CHECKSUM_EN
    localparam bit CS_EN = 1'b1;
`else
    localparam bit CS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_start;
    logic [18:0] cmd_base;
    logic [19:0] cmd_len;
    logic        cmd_abort;
    logic [18:0] mem_rd_addr;
    logic        mem_rd_en;
    logic [31:0] mem_rd_data;
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_last;
    logic        m_ready;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] checksum;

    int checks = 0;
    int errors = 0;

    // Memory content and sink behaviour knobs
    bit          ident_mode = 1'b0;
    logic [31:0] salt = 32'h0;
    int          ready_mode = 0;

    // Transaction-level reference state
    bit          model_busy = 1'b0;
    int          m_base, m_len, issued, accepted, max_occ;
    bit          done_next = 1'b0, err_next = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic [31:0] sum = 32'h0;
    int          beats_total = 0, rd_total = 0, done_total = 0, err_total = 0;

    output_readback_dma dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_start   (cmd_start),
        .cmd_base    (cmd_base),
        .cmd_len     (cmd_len),
        .cmd_abort   (cmd_abort),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_data (mem_rd_data),
        .m_valid     (m_valid),
        .m_data      (m_data),
        .m_last      (m_last),
        .m_ready     (m_ready),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .checksum    (checksum)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input int addr);
        if (ident_mode) return 32'(addr);
        return (32'(addr) * 32'h9E3779B1) ^ salt;
    endfunction

    // output_memory: one-cycle registered read
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem_fn(int'(mem_rd_addr));
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = !m_ready;
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic apply_stimulus(input int base, input int len);
        cmd_base  = 19'(base);
        cmd_len   = 20'(len);
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles);
        int n = 0;
        while (model_busy && n < max_cycles) begin
            tick();
            n++;
        end
        check_output("wait_idle", 32'(model_busy), 32'd0);
        tick();
    endtask

    // Reference model: sampled away from the active edge, judged from the stream rules
    always @(negedge clk) begin
        bit was_busy;
        if (!rst_n) begin
            model_busy = 1'b0;
            done_next  = 1'b0;
            err_next   = 1'b0;
            prev_stall = 1'b0;
            sum        = 32'h0;
        end else begin
            was_busy = model_busy;
            check_output("busy", 32'(busy), 32'(model_busy));
            check_output("done", 32'(done), 32'(done_next));
            check_output("err", 32'(err), 32'(err_next));
            check_output("checksum", checksum, CS_EN ? sum : 32'h0);
            if (done) done_total++;
            if (err)  err_total++;
            done_next = 1'b0;
            err_next  = 1'b0;
            if (!was_busy) begin
                check_output("idle_rd_en", 32'(mem_rd_en), 32'd0);
                check_output("idle_valid", 32'(m_valid), 32'd0);
                if (cmd_start) begin
                    if (int'(cmd_base) + int'(cmd_len) > DEPTH) err_next = 1'b1;
                    else if (cmd_len == 0) done_next = 1'b1;
                    else begin
                        model_busy = 1'b1;
                        m_base     = int'(cmd_base);
                        m_len      = int'(cmd_len);
                        issued     = 0;
                        accepted   = 0;
                        max_occ    = 0;
                        sum        = 32'h0;
                        prev_stall = 1'b0;
                    end
                end
            end else begin
                if (prev_stall) begin
                    check_output("stall_valid", 32'(m_valid), 32'd1);
                    check_output("stall_data", m_data, prev_data);
                end
                if (issued - accepted > max_occ) max_occ = issued - accepted;
                if (mem_rd_en) begin
                    check_output("rd_addr", 32'(mem_rd_addr), 32'(m_base + issued));
                    check_output("rd_credit", 32'((issued - accepted) < FIFO_DEPTH && issued < m_len), 32'd1);
                    issued++;
                    rd_total++;
                end
                if (m_valid && m_ready) begin
                    check_output("beat_data", m_data, mem_fn(m_base + accepted));
                    check_output("beat_last", 32'(m_last), 32'(accepted == m_len - 1));
                    sum = sum + m_data;
                    accepted++;
                    beats_total++;
                    if (accepted == m_len) begin
                        model_busy = 1'b0;
                        done_next  = 1'b1;
                    end
                end
                prev_stall = m_valid && !m_ready;
                prev_data  = m_data;
                if (cmd_abort) begin
                    model_busy = 1'b0;
                    done_next  = 1'b0;
                    prev_stall = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int beats0, rd0, done0, err0, n;
        rst_n     = 1'b0;
        cmd_start = 1'b0;
        cmd_base  = '0;
        cmd_len   = '0;
        cmd_abort = 1'b0;
        m_ready   = 1'b1;
        salt      = $urandom;
        #1;
        check_output("reset_busy", 32'(busy), 32'd0);
        check_output("reset_valid", 32'(m_valid), 32'd0);
        check_output("reset_rd_en", 32'(mem_rd_en), 32'd0);
        check_output("reset_data", m_data, 32'd0);
        check_output("reset_checksum", checksum, 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        $display("[TB] base=0 len=8 full rate");
        beats0 = beats_total; rd0 = rd_total; done0 = done_total;
        apply_stimulus(0, 8);
        @(negedge clk);
        check_output("lat_rd_en_t1", 32'(mem_rd_en), 32'd1);
        check_output("lat_valid_t1", 32'(m_valid), 32'd0);
        @(negedge clk);
        check_output("lat_valid_t2", 32'(m_valid), 32'd0);
        @(negedge clk);
        check_output("lat_valid_t3", 32'(m_valid), 32'd1);
        wait_idle(100);
        check_output("t1_beats", 32'(beats_total - beats0), 32'd8);
        check_output("t1_reads", 32'(rd_total - rd0), 32'd8);
        check_output("t1_done", 32'(done_total - done0), 32'd1);

        $display("[TB] base=100 len=16 toggling ready, start while busy");
        ready_mode = 1;
        beats0 = beats_total; err0 = err_total;
        apply_stimulus(100, 16);
        repeat (3) tick();
        apply_stimulus(301050, 7);
        wait_idle(200);
        check_output("t2_beats", 32'(beats_total - beats0), 32'd16);
        check_output("t2_max_occ", 32'(max_occ), 32'(FIFO_DEPTH));
        check_output("t2_no_err", 32'(err_total - err0), 32'd0);

        $display("[TB] bounds check at top of memory");
        ready_mode = 0;
        rd0 = rd_total; err0 = err_total;
        apply_stimulus(301050, 7);
        repeat (2) tick();
        check_output("t3_err", 32'(err_total - err0), 32'd1);
        check_output("t3_no_read", 32'(rd_total - rd0), 32'd0);
        beats0 = beats_total; done0 = done_total;
        apply_stimulus(301050, 6);
        wait_idle(100);
        check_output("t3_beats", 32'(beats_total - beats0), 32'd6);
        check_output("t3_done", 32'(done_total - done0), 32'd1);

        $display("[TB] zero-length command");
        beats0 = beats_total; done0 = done_total;
        apply_stimulus(5, 0);
        repeat (2) tick();
        check_output("t4_done", 32'(done_total - done0), 32'd1);
        check_output("t4_beats", 32'(beats_total - beats0), 32'd0);

        $display("[TB] abort after 10 beats");
        done0 = done_total;
        apply_stimulus(500, 32);
        n = 0;
        while (accepted < 10 && n < 100) begin
            tick();
            n++;
        end
        check_output("t5_reach_10", 32'(accepted >= 10), 32'd1);
        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        @(negedge clk);
        check_output("t5_valid_low", 32'(m_valid), 32'd0);
        check_output("t5_busy_low", 32'(busy), 32'd0);
        repeat (5) tick();
        check_output("t5_no_done", 32'(done_total - done0), 32'd0);
        ready_mode = 2;
        beats0 = beats_total;
        apply_stimulus(2000, 20);
        wait_idle(300);
        check_output("t5_restart_beats", 32'(beats_total - beats0), 32'd20);

        $display("[TB] checksum with mem[i]=i");
        ident_mode = 1'b1;
        ready_mode = 0;
        apply_stimulus(0, 10);
        wait_idle(100);
        check_output("t6_checksum", checksum, CS_EN ? 32'd45 : 32'd0);
        ident_mode = 1'b0;

        $display("[TB] random commands");
        ready_mode = 2;
        for (int k = 0; k < 8; k++) begin
            int base, len;
            salt = $urandom;
            if (k % 4 == 3) begin
                base = DEPTH - 10;
                len  = $urandom_range(1, 20);
            end else begin
                base = $urandom_range(0, DEPTH - 64);
                len  = $urandom_range(1, 24);
            end
            beats0 = beats_total;
            apply_stimulus(base, len);
            wait_idle(400);
            check_output("rand_beats", 32'(beats_total - beats0), (base + len <= DEPTH) ? 32'(len) : 32'd0);
        end

        $display("[TB] reset mid-transfer");
        ready_mode = 0;
        apply_stimulus(1000, 20);
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        check_output("mid_reset_busy", 32'(busy), 32'd0);
        check_output("mid_reset_valid", 32'(m_valid), 32'd0);
        check_output("mid_reset_rd_en", 32'(mem_rd_en), 32'd0);
        check_output("mid_reset_checksum", checksum, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        beats0 = beats_total;
        apply_stimulus(64, 5);
        wait_idle(100);
        check_output("post_reset_beats", 32'(beats_total - beats0), 32'd5);

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
